// File: rtl/pipe_stall_ctrl.sv
// Pipeline flow controller: turns per-stage stall requests into a stall vector,
// sequences redirect flushes and tracks how long the pipeline has been stalled.
module pipe_stall_ctrl #(
  parameter int unsigned NUM_STAGES    = 6,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned STALL_TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  flush_req,
  input  logic [ADDR_W-1:0]     flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [ADDR_W-1:0]     new_pc,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  timeout
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STALL_TIMEOUT);

  if (NUM_STAGES < 2) begin : g_chk_stages
    $error("pipe_stall_ctrl: NUM_STAGES must be at least 2");
  end
  if (FLUSH_CYCLES < 1) begin : g_chk_flush
    $error("pipe_stall_ctrl: FLUSH_CYCLES must be at least 1");
  end
  if (STALL_TIMEOUT >= (64'd1 << CNT_W)) begin : g_chk_timeout
    $error("pipe_stall_ctrl: STALL_TIMEOUT must fit in CNT_W bits");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e            state_q,     state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              flush_q,     flush_d;
  logic [ADDR_W-1:0] new_pc_q,    new_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              timeout_q,   timeout_d;

  logic [NUM_STAGES-1:0] stall_pfx;
  logic                  stall_any;

  // A stalled stage must also hold every older stage below it: suffix-OR from the top.
  always_comb begin
    logic run;
    run       = 1'b0;
    stall_pfx = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      run          = run | stall_req[k];
      stall_pfx[k] = run;
    end
  end

  assign stall     = (rst || state_q == ST_FLUSH) ? '0 : stall_pfx;
  assign stall_any = |stall_pfx;

  // Next-state, flush sequencing and stall-cycle accounting.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    new_pc_d    = new_pc_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FC_RELOAD;
          new_pc_d    = flush_pc;
        end
      end
      ST_FLUSH: begin
        if (flush_req) begin
          flush_cnt_d = FC_RELOAD;
          new_pc_d    = flush_pc;
        end else if (flush_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush empties the pipe, so any stall run is over.
    if (state_q == ST_FLUSH || flush_req) begin
      stall_cnt_d = '0;
    end else if (stall_any) begin
      stall_cnt_d = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = '0;
    end

    flush_d   = (state_d == ST_FLUSH);
    timeout_d = (stall_cnt_d >= CNT_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      flush_q     <= 1'b0;
      new_pc_q    <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      flush_q     <= flush_d;
      new_pc_q    <= new_pc_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign flush     = flush_q;
  assign new_pc    = new_pc_q;
  assign stall_cnt = stall_cnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model of the stall/flush/counter rules.
module tb_pipe_stall_ctrl;

  localparam int NS  = 6;
  localparam int AW  = 32;
  localparam int FC  = 3;
  localparam int CW  = 3;
  localparam int TO  = 4;
  localparam int CMX = 7;

  logic          clk;
  logic          rst;
  logic [NS-1:0] stall_req;
  logic          flush_req;
  logic [AW-1:0] flush_pc;
  logic [NS-1:0] stall;
  logic          flush;
  logic [AW-1:0] new_pc;
  logic [CW-1:0] stall_cnt;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: flush cycles still to show, last redirect, stall run length.
  int            m_left = 0;
  logic [AW-1:0] m_pc   = '0;
  int            m_cnt  = 0;

  pipe_stall_ctrl #(
    .NUM_STAGES(NS), .ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(CW), .STALL_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cnt(stall_cnt), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NS-1:0] ref_stall(input logic r, input logic [NS-1:0] req,
                                              input int left);
    int v;
    if (r || left > 0) return '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (req[k]) begin
        v = (1 << (k + 1)) - 1;
        return v[NS-1:0];
      end
    end
    return '0;
  endfunction

  task automatic drive(input logic r, input logic [NS-1:0] sreq, input logic freq,
                       input logic [AW-1:0] fpc);
    rst = r; stall_req = sreq; flush_req = freq; flush_pc = fpc;
    #1;
  endtask

  // Advance one clock and apply the same inputs to the model.
  task automatic tick();
    logic [NS-1:0] sv;
    bit in_fl;
    @(posedge clk);
    sv    = ref_stall(1'b0, stall_req, m_left);
    in_fl = (m_left > 0);
    if (rst) begin
      m_left = 0; m_pc = '0; m_cnt = 0;
    end else begin
      if (flush_req) begin
        m_left = FC; m_pc = flush_pc;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
      end
      if (in_fl || flush_req) m_cnt = 0;
      else if (sv != '0)      m_cnt = (m_cnt < CMX) ? m_cnt + 1 : CMX;
      else                    m_cnt = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 6'b101010, 1'b1, 32'h1234_5678);
    checks++;
    if (stall !== 6'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected %b", stall, 6'b0);
    end
    tick(); tick();
    checks++;
    if (flush !== 1'b0 || new_pc !== 32'h0 || stall_cnt !== 3'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got flush=%b new_pc=%h cnt=%0d to=%b expected 0/0/0/0",
               flush, new_pc, stall_cnt, timeout);
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_priority();
    logic [NS-1:0] req_t [6] = '{6'b000100, 6'b010100, 6'b100000, 6'b000000,
                                 6'b000001, 6'b110011};
    logic [NS-1:0] exp_t [6] = '{6'b000111, 6'b011111, 6'b111111, 6'b000000,
                                 6'b000001, 6'b111111};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, req_t[i], 1'b0, 32'h0);
      checks++;
      if (stall !== exp_t[i]) begin
        errors++;
        $display("FAIL priority[%0d]: req=%b got %b expected %b", i, req_t[i], stall, exp_t[i]);
      end
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_flush_timing();
    drive(1'b0, 6'b000100, 1'b0, 32'h0);
    tick(); tick();
    drive(1'b0, 6'b000100, 1'b1, 32'hBFC0_0380);
    checks++;
    if (stall !== 6'b000111) begin
      errors++; $display("FAIL flush_same_cycle_stall: got %b expected %b", stall, 6'b000111);
    end
    tick();
    for (int i = 0; i < FC; i++) begin
      drive(1'b0, 6'b000100, 1'b0, 32'h0);
      checks++;
      if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380 || stall !== 6'b0 || stall_cnt !== 3'd0) begin
        errors++;
        $display("FAIL flush_cycle[%0d]: got flush=%b pc=%h stall=%b cnt=%0d expected 1/bfc00380/000000/0",
                 i, flush, new_pc, stall, stall_cnt);
      end
      tick();
    end
    checks++;
    if (flush !== 1'b0 || stall !== 6'b000111 || new_pc !== 32'hBFC0_0380) begin
      errors++;
      $display("FAIL flush_end: got flush=%b stall=%b pc=%h expected 0/000111/bfc00380",
               flush, stall, new_pc);
    end
    tick();
    checks++;
    if (stall_cnt !== 3'd1) begin
      errors++; $display("FAIL flush_then_count: got %0d expected 1", stall_cnt);
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 6'b0, 1'b1, 32'hAAAA_0000);
    tick();
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'hAAAA_0000) begin
      errors++; $display("FAIL b2b_first: got flush=%b pc=%h expected 1/aaaa0000", flush, new_pc);
    end
    drive(1'b0, 6'b0, 1'b1, 32'hBBBB_0004);
    tick();
    for (int i = 0; i < FC; i++) begin
      checks++;
      if (flush !== 1'b1 || new_pc !== 32'hBBBB_0004) begin
        errors++;
        $display("FAIL b2b_second[%0d]: got flush=%b pc=%h expected 1/bbbb0004", i, flush, new_pc);
      end
      drive(1'b0, 6'b0, 1'b0, 32'h0);
      tick();
    end
    checks++;
    if (flush !== 1'b0 || new_pc !== 32'hBBBB_0004) begin
      errors++; $display("FAIL b2b_end: got flush=%b pc=%h expected 0/bbbb0004", flush, new_pc);
    end
  endtask

  task automatic test_timeout();
    drive(1'b0, 6'b0, 1'b0, 32'h0);
    tick();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, 6'b000010, 1'b0, 32'h0);
      tick();
      checks++;
      if (stall_cnt !== 3'(i) || timeout !== (i >= TO)) begin
        errors++;
        $display("FAIL timeout_run[%0d]: got cnt=%0d to=%b expected cnt=%0d to=%b",
                 i, stall_cnt, timeout, i, (i >= TO));
      end
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (stall_cnt !== 3'd0 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got cnt=%0d to=%b expected 0/0", stall_cnt, timeout);
    end
  endtask

  task automatic test_saturation();
    int e;
    for (int i = 1; i <= 12; i++) begin
      drive(1'b0, 6'b100000, 1'b0, 32'h0);
      tick();
      e = (i < CMX) ? i : CMX;
      checks++;
      if (stall_cnt !== 3'(e) || timeout !== (e >= TO)) begin
        errors++;
        $display("FAIL saturate[%0d]: got cnt=%0d to=%b expected cnt=%0d to=%b",
                 i, stall_cnt, timeout, e, (e >= TO));
      end
    end
    drive(1'b0, 6'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b0, 6'b0, 1'b1, 32'hCAFE_0010);
    tick();
    drive(1'b0, 6'b111111, 1'b0, 32'h0);
    tick();
    drive(1'b1, 6'b111111, 1'b1, 32'hDEAD_BEEC);
    checks++;
    if (flush !== 1'b1 || stall !== 6'b0) begin
      errors++; $display("FAIL rst_mid_pre: got flush=%b stall=%b expected 1/000000", flush, stall);
    end
    tick();
    checks++;
    if (flush !== 1'b0 || stall_cnt !== 3'd0 || timeout !== 1'b0 || new_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_post: got flush=%b cnt=%0d to=%b pc=%h expected 0/0/0/0",
               flush, stall_cnt, timeout, new_pc);
    end
    drive(1'b0, 6'b111111, 1'b0, 32'h0);
    checks++;
    if (stall !== 6'b111111) begin
      errors++; $display("FAIL rst_mid_release: got stall=%b expected 111111", stall);
    end
    tick();
    checks++;
    if (flush !== 1'b0 || stall_cnt !== 3'd1) begin
      errors++; $display("FAIL rst_mid_after: got flush=%b cnt=%0d expected 0/1", flush, stall_cnt);
    end
  endtask

  task automatic test_random();
    logic          r, fq;
    logic [NS-1:0] sq, es;
    logic [AW-1:0] pc;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      fq = ($urandom_range(0, 9) == 0);
      sq = ($urandom_range(0, 3) == 0) ? 6'b0 : 6'($urandom);
      pc = $urandom;
      drive(r, sq, fq, pc);
      es = ref_stall(r, sq, m_left);
      checks++;
      if (stall !== es) begin
        errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, stall, es);
      end
      tick();
      checks++;
      if (flush !== (m_left > 0) || new_pc !== m_pc || stall_cnt !== 3'(m_cnt)
          || timeout !== (m_cnt >= TO)) begin
        errors++;
        $display("FAIL rand_regs[%0d]: got flush=%b pc=%h cnt=%0d to=%b expected %b/%h/%0d/%b",
                 i, flush, new_pc, stall_cnt, timeout, (m_left > 0), m_pc, m_cnt, (m_cnt >= TO));
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_flush_timing();
    test_back_to_back();
    test_timeout();
    test_saturation();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
